// File: rtl/board_fifo_reader_if.sv
// rtl/board_fifo_reader_if.sv - SpyBuffer read side, framed output stream and counters of one board reader
//
// Purpose: bundles every non-clock signal of board_fifo_reader.
// Signals:
//   fifo_empty        SpyBuffer empty flag (toward reader)
//   fifo_read_data    SpyBuffer read data, valid one cycle after fifo_read_enable
//   fifo_read_enable  read request to the SpyBuffer (from reader)
//   out_data/out_valid/out_sop/out_eop  head of the output buffer (from reader)
//   out_ready         downstream accept (toward reader)
//   in_event          header accepted, footer not yet accepted
//   event_count/word_count/error_count  free-running statistics
// Modports: master = reader side, slave = SpyBuffer + downstream side.
interface board_fifo_reader_if #(
  parameter int DATA_WIDTH  = 65,
  parameter int COUNT_WIDTH = 32
);
  logic                   fifo_empty;
  logic [DATA_WIDTH-1:0]  fifo_read_data;
  logic                   fifo_read_enable;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_sop;
  logic                   out_eop;
  logic                   in_event;
  logic [COUNT_WIDTH-1:0] event_count;
  logic [COUNT_WIDTH-1:0] word_count;
  logic [COUNT_WIDTH-1:0] error_count;

  modport master (
    input  fifo_empty, fifo_read_data, out_ready,
    output fifo_read_enable, out_data, out_valid, out_sop, out_eop,
           in_event, event_count, word_count, error_count
  );

  modport slave (
    output fifo_empty, fifo_read_data, out_ready,
    input  fifo_read_enable, out_data, out_valid, out_sop, out_eop,
           in_event, event_count, word_count, error_count
  );
endinterface

// File: rtl/board_fifo_reader.sv
// rtl/board_fifo_reader.sv - drains one SpyBuffer FIFO into a framed valid/ready word stream
//
// Purpose: issues SpyBuffer reads against its one-cycle read latency, rebuilds
// event framing from the metadata flag (top bit), buffers up to two words for
// back-pressure and keeps event/word/error counters.
// Ports:
//   clock  rising-edge clock for all logic
//   reset  asynchronous, active-high; clears all state and blocks reads
//   bus    board_fifo_reader_if.master (SpyBuffer read side, output stream, counters)
module board_fifo_reader #(
  parameter int DATA_WIDTH  = 65,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  board_fifo_reader_if.master  bus
);

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_EVENT = 1'b1
  } state_e;

  state_e                              state_q, state_d;
  logic                                in_event_q;
  logic                                inflight_q;
  logic [1:0][DATA_WIDTH-1:0]          buf_data_q;
  logic [1:0]                          buf_sop_q;
  logic [1:0]                          buf_eop_q;
  logic                                rd_ptr_q;
  logic                                wr_ptr_q;
  logic [1:0]                          occ_q, occ_d;
  logic [COUNT_WIDTH-1:0]              event_count_q;
  logic [COUNT_WIDTH-1:0]              word_count_q;
  logic [COUNT_WIDTH-1:0]              error_count_q;

  logic       ret_meta;
  logic       push, drop, push_sop, push_eop;
  logic       pop;
  logic       out_valid;
  logic [2:0] credit_used;
  logic       rd_en;

  assign ret_meta  = bus.fifo_read_data[DATA_WIDTH-1];
  assign out_valid = (occ_q != 2'd0);
  assign pop       = out_valid & bus.out_ready;

  // Framing decision for the word returning this cycle (read issued last cycle).
  always_comb begin
    push     = 1'b0;
    drop     = 1'b0;
    push_sop = 1'b0;
    push_eop = 1'b0;
    state_d  = state_q;
    if (inflight_q) begin
      case (state_q)
        ST_IDLE: begin
          if (ret_meta) begin
            push     = 1'b1;
            push_sop = 1'b1;
            state_d  = ST_IN_EVENT;
          end else begin
            drop = 1'b1;
          end
        end
        ST_IN_EVENT: begin
          push = 1'b1;
          if (ret_meta) begin
            push_eop = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Every outstanding read owns a buffer slot until it returns, so the buffer
  // never overflows; a popping head frees its slot for a read in the same cycle.
  assign credit_used = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
  assign rd_en       = ~reset & ~bus.fifo_empty & (credit_used < 3'd2);

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      in_event_q    <= 1'b0;
      inflight_q    <= 1'b0;
      buf_data_q    <= '0;
      buf_sop_q     <= '0;
      buf_eop_q     <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      occ_q         <= 2'd0;
      event_count_q <= '0;
      word_count_q  <= '0;
      error_count_q <= '0;
    end else begin
      state_q    <= state_d;
      in_event_q <= (state_d == ST_IN_EVENT);
      inflight_q <= rd_en;
      occ_q      <= occ_d;
      if (push) begin
        buf_data_q[wr_ptr_q] <= bus.fifo_read_data;
        buf_sop_q[wr_ptr_q]  <= push_sop;
        buf_eop_q[wr_ptr_q]  <= push_eop;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q     <= ~rd_ptr_q;
        word_count_q <= word_count_q + COUNT_WIDTH'(1);
        if (buf_eop_q[rd_ptr_q]) begin
          event_count_q <= event_count_q + COUNT_WIDTH'(1);
        end
      end
      if (drop) begin
        error_count_q <= error_count_q + COUNT_WIDTH'(1);
      end
    end
  end

  // Head fields are forced to zero when the buffer is empty so stale slots never show.
  assign bus.fifo_read_enable = rd_en;
  assign bus.out_valid        = out_valid;
  assign bus.out_data         = out_valid ? buf_data_q[rd_ptr_q] : '0;
  assign bus.out_sop          = out_valid & buf_sop_q[rd_ptr_q];
  assign bus.out_eop          = out_valid & buf_eop_q[rd_ptr_q];
  assign bus.in_event         = in_event_q;
  assign bus.event_count      = event_count_q;
  assign bus.word_count       = word_count_q;
  assign bus.error_count      = error_count_q;

endmodule
